b_loc_ctrl: RTL and testbench

Operand-b location controller for the modular multiply/divide datapath. It drives the b-flag register's update port (`b_flag_in`, `b_flag_we`) and consumes its output (`b_flag`) to decide where operand b is read from on each iteration. It steers the source select and ping-pongs each iteration's result between regc and regd. It runs a fixed number of iterations per `mmul_en` start, handshaking each step with the datapath.

---
 rtl/b_loc_ctrl_if.sv | 28 ++
 rtl/b_loc_ctrl.sv | 123 ++++++++++++
 tb/tb_b_loc_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/b_loc_ctrl_if.sv
// Handshake and b-flag bundle between b_loc_ctrl (master) and the datapath /
// b-flag register (slave).
interface b_loc_ctrl_if #(
  parameter int unsigned CW = 9
);
  logic          mmul_en;
  logic [1:0]    b_flag;
  logic          op_ack;
  logic          op_req;
  logic [2:0]    sel_b;
  logic [2:0]    wr_sel;
  logic [1:0]    b_flag_in;
  logic          b_flag_we;
  logic          busy;
  logic [CW-1:0] iter;
  logic          done;
  logic          err;

  modport master (
    input  mmul_en, b_flag, op_ack,
    output op_req, sel_b, wr_sel, b_flag_in, b_flag_we, busy, iter, done, err
  );

  modport slave (
    output mmul_en, b_flag, op_ack,
    input  op_req, sel_b, wr_sel, b_flag_in, b_flag_we, busy, iter, done, err
  );
endinterface

// File: rtl/b_loc_ctrl.sv
// Operand-b location controller: steers b reads and ping-pongs results between regc/regd.
// Optional B_LOC_ERR_EN: flag value 11 in ISSUE aborts the operation and sets sticky err.
module b_loc_ctrl #(
  parameter int unsigned N_ITER = 256,
  parameter int unsigned CW     = 9
) (
  input  logic         clk,
  input  logic         rst,
  b_loc_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, WAIT, ISSUE, COMMIT, SYNC, DONE} state_e;

  localparam logic [CW-1:0] LAST = CW'(N_ITER);

  state_e        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          dst_regd_q, dst_regd_d;
  logic          flag_abort;
  logic          kill;

`ifdef B_LOC_ERR_EN
  logic err_q, err_d;

  assign flag_abort = (state_q == ISSUE) && (bus.b_flag == 2'b11);

  always_comb begin
    err_d = err_q;
    if (bus.mmul_en) begin
      err_d = 1'b0;
    end else if (flag_abort) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign flag_abort = 1'b0;
  assign bus.err    = 1'b0;
`endif

  // Destination is latched on the ack so COMMIT decodes only registered state.
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    dst_regd_d = dst_regd_q;
    unique case (state_q)
      IDLE:   state_d = IDLE;
      WAIT:   state_d = ISSUE;
      ISSUE: begin
        if (flag_abort) begin
          state_d = IDLE;
        end else if (bus.op_ack) begin
          state_d    = COMMIT;
          dst_regd_d = (bus.b_flag == 2'b00);
        end
      end
      COMMIT: begin
        state_d = SYNC;
        iter_d  = iter_q + CW'(1);
      end
      SYNC:   state_d = (iter_q == LAST) ? DONE : ISSUE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.mmul_en) begin
      state_d = WAIT;
      iter_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      iter_q     <= '0;
      dst_regd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      dst_regd_q <= dst_regd_d;
    end
  end

  // A restart (or an abort) drops every strobe in the cycle it is seen.
  always_comb begin
    kill          = bus.mmul_en | flag_abort;
    bus.op_req    = 1'b0;
    bus.sel_b     = '0;
    bus.wr_sel    = '0;
    bus.b_flag_in = '0;
    bus.b_flag_we = 1'b0;
    bus.done      = 1'b0;
    if (!kill) begin
      unique case (state_q)
        ISSUE: begin
          bus.op_req = 1'b1;
          unique case (bus.b_flag)
            2'b00:   bus.sel_b = 3'b001;
            2'b01:   bus.sel_b = 3'b010;
            default: bus.sel_b = 3'b100;
          endcase
        end
        COMMIT: begin
          bus.b_flag_we = 1'b1;
          bus.wr_sel    = dst_regd_q ? 3'b010 : 3'b001;
          bus.b_flag_in = {1'b0, dst_regd_q};
        end
        DONE:    bus.done = 1'b1;
        default: bus.done = 1'b0;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.iter = iter_q;
endmodule

// File: tb/tb_b_loc_ctrl.sv
// Bench for b_loc_ctrl: two instances (N_ITER=4 and N_ITER=3), each with its own
// b-flag register, an ack responder and a transaction-level reference model.
module tb_b_loc_ctrl;
`ifdef B_LOC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  b_loc_ctrl_if #(.CW(3)) if4 ();
  b_loc_ctrl_if #(.CW(2)) if3 ();

  b_loc_ctrl #(.N_ITER(4), .CW(3)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  b_loc_ctrl #(.N_ITER(3), .CW(2)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  // Stimulus per instance (index 0: N_ITER=4, index 1: N_ITER=3)
  logic       mmul_en [2];
  logic       force11 [2];
  logic       ack_man [2];
  int         ack_dly [2];
  logic [1:0] flag_q  [2];
  int         req_cnt [2];
  int         n_iter  [2];

  // Observed signals
  logic       o_req [2], o_we [2], o_busy [2], o_done [2], o_err [2], o_ack [2];
  logic [2:0] o_sel [2], o_wr [2];
  logic [1:0] o_fin [2], o_bflag [2];
  int         o_iter [2];

  assign if4.mmul_en = mmul_en[0];
  assign if3.mmul_en = mmul_en[1];
  assign if4.b_flag  = force11[0] ? 2'b11 : flag_q[0];
  assign if3.b_flag  = force11[1] ? 2'b11 : flag_q[1];
  assign if4.op_ack  = ack_man[0] | (if4.op_req && (req_cnt[0] == ack_dly[0]));
  assign if3.op_ack  = ack_man[1] | (if3.op_req && (req_cnt[1] == ack_dly[1]));

  assign o_req[0] = if4.op_req;    assign o_req[1] = if3.op_req;
  assign o_sel[0] = if4.sel_b;     assign o_sel[1] = if3.sel_b;
  assign o_wr[0]  = if4.wr_sel;    assign o_wr[1]  = if3.wr_sel;
  assign o_fin[0] = if4.b_flag_in; assign o_fin[1] = if3.b_flag_in;
  assign o_we[0]  = if4.b_flag_we; assign o_we[1]  = if3.b_flag_we;
  assign o_busy[0] = if4.busy;     assign o_busy[1] = if3.busy;
  assign o_done[0] = if4.done;     assign o_done[1] = if3.done;
  assign o_err[0] = if4.err;       assign o_err[1] = if3.err;
  assign o_iter[0] = int'(if4.iter);
  assign o_iter[1] = int'(if3.iter);
  assign o_bflag[0] = if4.b_flag;  assign o_bflag[1] = if3.b_flag;
  assign o_ack[0] = if4.op_ack;    assign o_ack[1] = if3.op_ack;

  // External b-flag register: mmul_en has priority over the update port.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        flag_q[d]  <= 2'b00;
        req_cnt[d] <= 0;
      end else begin
        if (mmul_en[d])   flag_q[d] <= 2'b10;
        else if (o_we[d]) flag_q[d] <= o_fin[d];
        req_cnt[d] <= o_req[d] ? req_cnt[d] + 1 : 0;
      end
    end
  end

  // Reference model: operation progress as phase flags plus completed count.
  logic m_active [2], m_lead [2], m_req [2], m_wr [2], m_settle [2], m_fin [2];
  logic m_dstd [2], m_err [2];
  int   m_iters [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_active[d] <= 0; m_lead[d] <= 0; m_req[d] <= 0; m_wr[d] <= 0;
        m_settle[d] <= 0; m_fin[d] <= 0; m_dstd[d] <= 0; m_err[d] <= 0;
        m_iters[d]  <= 0;
      end else if (mmul_en[d]) begin
        m_active[d] <= 1; m_lead[d] <= 1; m_req[d] <= 0; m_wr[d] <= 0;
        m_settle[d] <= 0; m_fin[d] <= 0; m_err[d] <= 0; m_iters[d] <= 0;
      end else if (m_lead[d]) begin
        m_lead[d] <= 0; m_req[d] <= 1;
      end else if (m_req[d]) begin
        if (ERR_EN && o_bflag[d] == 2'b11) begin
          m_req[d] <= 0; m_active[d] <= 0; m_err[d] <= 1;
        end else if (o_ack[d]) begin
          m_req[d] <= 0; m_wr[d] <= 1; m_dstd[d] <= (o_bflag[d] == 2'b00);
        end
      end else if (m_wr[d]) begin
        m_wr[d] <= 0; m_settle[d] <= 1; m_iters[d] <= m_iters[d] + 1;
      end else if (m_settle[d]) begin
        m_settle[d] <= 0;
        if (m_iters[d] == n_iter[d]) m_fin[d] <= 1;
        else                         m_req[d] <= 1;
      end else if (m_fin[d]) begin
        m_fin[d] <= 0; m_active[d] <= 0;
      end
    end
  end

  function automatic logic [2:0] onehot(input logic [1:0] f);
    case (f)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   cmp_on = 0;
  int   start_cyc [2];
  int   done_cyc  [2];
  int   done_cnt  [2];
  int   fin_q [2][$];
  int   sel_q [2][$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 2; d++) begin
        logic        k;
        logic [45:0] act, exp;
        k = mmul_en[d] | (ERR_EN && m_req[d] && o_bflag[d] == 2'b11);
        exp = {m_req[d] & ~k,
               (m_req[d] & ~k) ? onehot(o_bflag[d]) : 3'b000,
               (m_wr[d] & ~k) ? (m_dstd[d] ? 3'b010 : 3'b001) : 3'b000,
               (m_wr[d] & ~k) ? {1'b0, m_dstd[d]} : 2'b00,
               m_wr[d] & ~k, m_active[d], m_fin[d] & ~k, m_err[d],
               32'(m_iters[d])};
        act = {o_req[d], o_sel[d], o_wr[d], o_fin[d], o_we[d], o_busy[d],
               o_done[d], o_err[d], 32'(o_iter[d])};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL cycle_model dut%0d cyc=%0d req/sel/wr/fin/we/busy/done/err/iter act=%h exp=%h",
                   d, cyc, act, exp);
        end
        if (mmul_en[d]) start_cyc[d] = cyc + 1;
        if (o_done[d]) begin done_cyc[d] = cyc; done_cnt[d]++; end
        if (o_we[d]) fin_q[d].push_back(int'(o_fin[d]));
        if (o_req[d] && o_ack[d]) sel_q[d].push_back(int'(o_sel[d]));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d);
    mmul_en[d] = 1'b1;
    tick();
    mmul_en[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_done[d]) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout dut%0d actual=no_done required=done within %0d cycles", d, budget);
    end
  endtask

  task automatic wait_sig_we(input int d, input int count, input int budget);
    int n = 0;
    for (int i = 0; i < budget && n < count; i++) begin
      tick();
      if (o_we[d]) n++;
    end
    chk("we_timeout", n, count);
  endtask

  task automatic clear_q(input int d);
    fin_q[d].delete();
    sel_q[d].delete();
  endtask

  initial begin
    n_iter[0] = 4; n_iter[1] = 3;
    for (int d = 0; d < 2; d++) begin
      mmul_en[d] = 0; force11[d] = 0; ack_man[d] = 0;
      start_cyc[d] = 0; done_cyc[d] = 0; done_cnt[d] = 0;
    end
    ack_dly[0] = 0; ack_dly[1] = 2;
    rst = 1'b1;
    tick(); tick();
    cmp_on = 1;
    chk("rst_busy", int'(o_busy[0]), 0);
    chk("rst_req",  int'(o_req[0]), 0);
    chk("rst_iter", o_iter[0], 0);
    chk("rst_err",  int'(o_err[1]), 0);
    rst = 1'b0;
    tick();

    // N_ITER=4 with immediate ack
    clear_q(0);
    start(0);
    wait_done(0, 40);
    tick();
    chk("n4_latency", done_cyc[0] - start_cyc[0], 13);
    chk("n4_iter", o_iter[0], 4);
    chk("n4_busy_after", int'(o_busy[0]), 0);
    chk("n4_final_flag", int'(flag_q[0]), 1);
    chk("n4_fin_count", fin_q[0].size(), 4);
    if (fin_q[0].size() == 4) begin
      chk("n4_fin0", fin_q[0][0], 0); chk("n4_fin1", fin_q[0][1], 1);
      chk("n4_fin2", fin_q[0][2], 0); chk("n4_fin3", fin_q[0][3], 1);
    end
    chk("n4_sel_count", sel_q[0].size(), 4);
    if (sel_q[0].size() == 4) begin
      chk("n4_sel0", sel_q[0][0], 4); chk("n4_sel1", sel_q[0][1], 1);
      chk("n4_sel2", sel_q[0][2], 2); chk("n4_sel3", sel_q[0][3], 1);
    end

    // N_ITER=3 with ack two cycles late
    start(1);
    wait_done(1, 80);
    tick();
    chk("n3_latency", done_cyc[1] - start_cyc[1], 16);
    chk("n3_final_flag", int'(flag_q[1]), 0);
    chk("n3_iter", o_iter[1], 3);

    // Restart during COMMIT of iteration 2
    start(0);
    wait_sig_we(0, 2, 40);
    clear_q(0);
    mmul_en[0] = 1'b1;
    #1;
    chk("restart_we_dropped", int'(o_we[0]), 0);
    chk("restart_wr_dropped", int'(o_wr[0]), 0);
    tick();
    mmul_en[0] = 1'b0;
    chk("restart_iter", o_iter[0], 0);
    chk("restart_busy", int'(o_busy[0]), 1);
    wait_done(0, 40);
    tick();
    chk("restart_latency", done_cyc[0] - start_cyc[0], 13);
    chk("restart_sel_count", sel_q[0].size(), 4);
    if (sel_q[0].size() > 0) chk("restart_sel0", sel_q[0][0], 4);

    // Reset while in ISSUE of the second iteration
    start(0);
    for (int i = 0; i < 20 && !(o_req[0] && o_iter[0] == 1); i++) tick();
    chk("pre_rst_issue", int'(o_req[0]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", int'(o_busy[0]), 0);
    chk("rst_mid_iter", o_iter[0], 0);
    chk("rst_mid_sel", int'(o_sel[0]), 0);
    start(0);
    wait_done(0, 40);
    tick();
    chk("post_rst_latency", done_cyc[0] - start_cyc[0], 13);

    // Illegal flag 11 while in ISSUE
    ack_dly[0] = -1;
    start(0);
    for (int i = 0; i < 10 && !o_req[0]; i++) tick();
    force11[0] = 1'b1;
    #1;
    if (ERR_EN) begin
      int dc;
      dc = done_cnt[0];
      chk("err_req_dropped", int'(o_req[0]), 0);
      tick();
      force11[0] = 1'b0;
      chk("err_set", int'(o_err[0]), 1);
      chk("err_busy", int'(o_busy[0]), 0);
      for (int i = 0; i < 5; i++) tick();
      chk("err_no_done", done_cnt[0], dc);
      chk("err_sticky", int'(o_err[0]), 1);
      ack_dly[0] = 0;
      start(0);
      chk("err_cleared", int'(o_err[0]), 0);
    end else begin
      chk("ill_sel", int'(o_sel[0]), 4);
      ack_man[0] = 1'b1;
      tick();
      ack_man[0] = 1'b0;
      force11[0] = 1'b0;
      chk("ill_wr", int'(o_wr[0]), 1);
      chk("ill_fin", int'(o_fin[0]), 0);
      ack_dly[0] = 0;
    end
    wait_done(0, 40);
    tick();

    // op_ack pulsed in IDLE, then in SYNC
    ack_man[0] = 1'b1;
    tick();
    ack_man[0] = 1'b0;
    chk("idle_ack_iter", o_iter[0], 4);
    chk("idle_ack_busy", int'(o_busy[0]), 0);
    chk("idle_ack_we", int'(o_we[0]), 0);
    start(0);
    wait_sig_we(0, 1, 20);
    tick();
    ack_man[0] = 1'b1;
    #1;
    chk("sync_ack_we", int'(o_we[0]), 0);
    chk("sync_ack_req", int'(o_req[0]), 0);
    tick();
    ack_man[0] = 1'b0;
    chk("sync_ack_iter", o_iter[0], 1);
    wait_done(0, 40);
    tick();
    chk("sync_ack_latency", done_cyc[0] - start_cyc[0], 13);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still_running required=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end
endmodule
